// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
// On a start request, snapshots every channel reading and streams one fixed
// 8-byte ASCII frame per channel ("C<ch>:<hhh>\r\n") into the UART transmit
// FIFO. Channel 0 goes first. The block waits while the FIFO reports full.
module uart_frame_scheduler #(
  parameter int NCH = 13,
  parameter int DW  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              done_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CH = 4'(NCH - 1);

  state_t            state_r, state_s;
  logic [3:0]        ch_idx_r, ch_idx_s;
  logic [2:0]        byte_idx_r, byte_idx_s;
  logic [NCH*DW-1:0] snap_r, snap_s;
  logic [DW-1:0]     cur_val_s;

  // Convert a nibble to an uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = 8'h30 + {4'h0, nib};
    end else begin
      res = 8'h37 + {4'h0, nib};
    end
    return res;
  endfunction

  // Register the state, the indices and the snapshot. Reset is synchronous and active low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      ch_idx_r   <= 4'd0;
      byte_idx_r <= 3'd0;
      snap_r     <= '0;
    end else begin
      state_r    <= state_s;
      ch_idx_r   <= ch_idx_s;
      byte_idx_r <= byte_idx_s;
      snap_r     <= snap_s;
    end
  end

  // Select the snapshot reading of the channel currently being framed.
  always_comb begin
    cur_val_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_idx_r == 4'(i)) begin
        cur_val_s = snap_r[i*DW +: DW];
      end else begin
        cur_val_s = cur_val_s;
      end
    end
  end

  // Build the frame byte for the current indices. The output is zero outside SEND.
  always_comb begin
    w_data = 8'h00;
    if (state_r == SEND) begin
      case (byte_idx_r)
        3'd0:    w_data = 8'h43;
        3'd1:    w_data = hex_ascii(ch_idx_r);
        3'd2:    w_data = 8'h3A;
        3'd3:    w_data = hex_ascii(cur_val_s[11:8]);
        3'd4:    w_data = hex_ascii(cur_val_s[7:4]);
        3'd5:    w_data = hex_ascii(cur_val_s[3:0]);
        3'd6:    w_data = 8'h0D;
        3'd7:    w_data = 8'h0A;
        default: w_data = 8'h00;
      endcase
    end else begin
      w_data = 8'h00;
    end
  end

  // Compute next-state logic and the write strobe. A write is blocked while the FIFO is full.
  always_comb begin
    state_s    = state_r;
    ch_idx_s   = ch_idx_r;
    byte_idx_s = byte_idx_r;
    snap_s     = snap_r;
    wr_uart    = 1'b0;
    busy       = 1'b0;
    done_tick  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          snap_s     = ch_data;
          ch_idx_s   = 4'd0;
          byte_idx_s = 3'd0;
          state_s    = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        busy    = 1'b1;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          if (byte_idx_r == 3'd7) begin
            byte_idx_s = 3'd0;
            if (ch_idx_r == LAST_CH) begin
              state_s = DONE;
            end else begin
              ch_idx_s = ch_idx_r + 4'd1;
            end
          end else begin
            byte_idx_s = byte_idx_r + 3'd1;
          end
        end else begin
          byte_idx_s = byte_idx_r;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done_tick = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler. It uses randomized channel data
// and checks every frame against a string-based reference model.
module tb_uart_frame_scheduler;

  localparam int NCH = 13;
  localparam int DW  = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NCH*DW-1:0] ch_data;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic              done_tick;

  int errors = 0;
  int checks = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] stall_bytes[$];
  int         full_wr_bad;
  int         busy_bad;

  uart_frame_scheduler #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .ch_data(ch_data),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .busy(busy), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*DW-1:0] rand_data();
    logic [NCH*DW-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*DW +: DW] = 12'($urandom);
    return d;
  endfunction

  // Reference model: expected byte stream, built as text.
  task automatic build_expected(input logic [NCH*DW-1:0] d);
    string hx;
    int v;
    hx = "0123456789ABCDEF";
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      v = int'(d[c*DW +: DW]);
      exp_q.push_back(8'h43);
      exp_q.push_back(8'(hx[c]));
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'(hx[v / 256]));
      exp_q.push_back(8'(hx[(v / 16) % 16]));
      exp_q.push_back(8'(hx[v % 16]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Stimulus only: accept a sweep, then run until done_tick. Written bytes go to got.
  task automatic drive_sweep(input logic [NCH*DW-1:0] data, input logic [NCH*DW-1:0] data_after,
                             input int stall_at, input int stall_len, input int rand_full,
                             input int p1, input int p2, output int cyc_done);
    int stall_left;
    bit stall_started;
    bit stall_cyc;
    got.delete(); stall_bytes.delete();
    full_wr_bad = 0; busy_bad = 0; cyc_done = -1;
    stall_left = 0; stall_started = 1'b0;
    start = 1'b1; ch_data = data; tx_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; ch_data = data_after;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (!stall_started && stall_len > 0 && got.size() == stall_at) begin
        stall_started = 1'b1; stall_left = stall_len;
      end
      stall_cyc = (stall_left > 0);
      if (stall_cyc) begin
        tx_full = 1'b1; stall_left--;
      end else begin
        tx_full = (rand_full != 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      start = (cyc == p1 || cyc == p2);
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (tx_full && wr_uart !== 1'b0) full_wr_bad++;
      if (stall_cyc) stall_bytes.push_back(w_data);
      if (wr_uart === 1'b1) got.push_back(w_data);
      if (done_tick === 1'b1) cyc_done = cyc;
      @(posedge clk); #1;
      if (cyc_done >= 0) break;
    end
    start = 1'b0; tx_full = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; tx_full = 1'b0; ch_data = rand_data();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (wr_uart !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b exp 0", wr_uart); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_tick); end
      checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h exp 00", w_data); end
    end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || wr_uart !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b wr=%b exp 0/0", busy, wr_uart); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nominal();
    logic [NCH*DW-1:0] d;
    int cd;
    d = rand_data();
    d[0 +: DW] = 12'hABC;
    d[12*DW +: DW] = 12'h05F;
    build_expected(d);
    drive_sweep(d, d, 0, 0, 0, 0, 0, cd);
    checks++; if (got.size() != 104) begin errors++; $display("FAIL nominal_count: got %0d exp 104", got.size()); end
    checks++; if (cd != 105) begin errors++; $display("FAIL nominal_done_cycle: got %0d exp 105", cd); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL nominal_busy: %0d low cycles exp 0", busy_bad); end
    if (got.size() == 104) begin
      checks++; if (got[3] !== 8'h41) begin errors++; $display("FAIL nominal_ch0_b3: got %h exp 41", got[3]); end
      checks++; if (got[101] !== 8'h46) begin errors++; $display("FAIL nominal_ch12_b5: got %h exp 46", got[101]); end
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL nominal_byte[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [NCH*DW-1:0] d;
    int cd;
    d = rand_data();
    build_expected(d);
    drive_sweep(d, d, 28, 5, 0, 0, 0, cd);
    checks++; if (full_wr_bad != 0) begin errors++; $display("FAIL bp_write_when_full: %0d cycles exp 0", full_wr_bad); end
    checks++; if (stall_bytes.size() != 5) begin errors++; $display("FAIL bp_stall_len: got %0d exp 5", stall_bytes.size()); end
    foreach (stall_bytes[i]) begin
      checks++; if (stall_bytes[i] !== exp_q[28]) begin errors++; $display("FAIL bp_held_byte[%0d]: got %h exp %h", i, stall_bytes[i], exp_q[28]); end
    end
    checks++; if (got.size() != 104) begin errors++; $display("FAIL bp_count: got %0d exp 104", got.size()); end
    checks++; if (cd != 110) begin errors++; $display("FAIL bp_done_cycle: got %0d exp 110", cd); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_backpressure();
    logic [NCH*DW-1:0] d;
    int cd;
    for (int r = 0; r < 2; r++) begin
      d = rand_data();
      build_expected(d);
      drive_sweep(d, d, 0, 0, 1, 0, 0, cd);
      checks++; if (cd < 105) begin errors++; $display("FAIL rbp_done: got cycle %0d exp >=105", cd); end
      checks++; if (full_wr_bad != 0) begin errors++; $display("FAIL rbp_write_when_full: %0d exp 0", full_wr_bad); end
      checks++; if (got.size() != 104) begin errors++; $display("FAIL rbp_count: got %0d exp 104", got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rbp_byte[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [NCH*DW-1:0] d;
    int cd;
    d = rand_data();
    build_expected(d);
    drive_sweep(d, ~d, 0, 0, 0, 0, 0, cd);
    checks++; if (got.size() != 104) begin errors++; $display("FAIL snap_count: got %0d exp 104", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL snap_byte[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_busy();
    logic [NCH*DW-1:0] d;
    int cd;
    d = rand_data();
    build_expected(d);
    drive_sweep(d, d, 0, 0, 0, 50, 105, cd);
    checks++; if (got.size() != 104 || cd != 105) begin errors++; $display("FAIL busy_start_sweep: writes=%0d done=%0d exp 104/105", got.size(), cd); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_uart !== 1'b0 || w_data !== 8'h00) begin
      errors++; $display("FAIL busy_start_restart: busy=%b wr=%b data=%h exp 0/0/00", busy, wr_uart, w_data);
    end
    @(posedge clk); #1;
    d = rand_data();
    build_expected(d);
    drive_sweep(d, d, 0, 0, 0, 0, 0, cd);
    checks++; if (got.size() != 104 || cd != 105) begin errors++; $display("FAIL busy_second_sweep: writes=%0d done=%0d exp 104/105", got.size(), cd); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL busy_second_byte[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [NCH*DW-1:0] d;
    int n;
    int cd;
    d = rand_data();
    n = 0;
    start = 1'b1; ch_data = d; tx_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 51; cyc++) begin
      @(negedge clk);
      if (wr_uart === 1'b1) n++;
      @(posedge clk); #1;
    end
    checks++; if (n != 51) begin errors++; $display("FAIL rmid_pre_count: got %0d exp 51", n); end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (wr_uart !== 1'b0 || busy !== 1'b0 || w_data !== 8'h00 || done_tick !== 1'b0) begin
        errors++; $display("FAIL rmid_abort: wr=%b busy=%b data=%h done=%b exp 0/0/00/0", wr_uart, busy, w_data, done_tick);
      end
      @(posedge clk); #1;
    end
    d = rand_data();
    build_expected(d);
    drive_sweep(d, d, 0, 0, 0, 0, 0, cd);
    checks++; if (got.size() != 104 || cd != 105) begin errors++; $display("FAIL rmid_resweep: writes=%0d done=%0d exp 104/105", got.size(), cd); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_byte[%0d]: got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; tx_full = 1'b0; ch_data = '0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_random_backpressure();
    test_snapshot();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
